// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI main controller.
//   - FSM state encodings (IDLE, SETUP, XFER, HOLD, DONE)
//   - SPI mode constants SPI_MODE0..SPI_MODE3, encoded as {cpol, cpha}
//   - clog2_min1: ceil(log2(n)), never less than 1, for sizing selects/counters
package spi_pkg;

  typedef logic [2:0] spi_state_t;

  localparam spi_state_t IDLE  = 3'd0;
  localparam spi_state_t SETUP = 3'd1;
  localparam spi_state_t XFER  = 3'd2;
  localparam spi_state_t HOLD  = 3'd3;
  localparam spi_state_t DONE  = 3'd4;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period tick generator for the SPI main controller.
// Counts clk cycles while enabled and pulses tick for one cycle every CLK_DIV cycles.
// Ports:
//   clk, rst - system clock, asynchronous active-high reset
//   en       - count enable (controller outside IDLE)
//   clr      - restart the count (transfer accepted, entering SETUP)
//   tick     - one-cycle pulse at the end of each half-period
module spi_clk_tick
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = clog2_min1(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_main_param.sv
// Parametrised full-duplex SPI main controller.
// Shifts one DATA_W-bit frame to one of NUM_CS sub devices. Mode (cpol/cpha), bit order
// and target are latched when start is accepted in IDLE.
// Sequence: IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE; SETUP and HOLD last one
// half-period, XFER 2*DATA_W half-periods of CLK_DIV cycles each.
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   start           - transfer request, sampled in IDLE only
//   cs_sel          - target chip select (values >= NUM_CS assert no line)
//   cpol, cpha      - SPI mode for the transfer
//   lsb_first       - 1 = LSB first, else MSB first
//   tx / rx         - frame to send / last received frame
//   busy, done      - transfer in progress / one-cycle completion pulse
//   sclk, mosi, miso, cs_n - SPI pins
// Build option SPI_LOOPBACK_EN adds input loopback: when latched high the receive shifter
// takes mosi instead of miso; pin timing is unchanged.
module spi_main_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned NUM_CS  = 1,
  localparam int unsigned CS_W   = clog2_min1(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic [DATA_W-1:0] tx,
  output logic [DATA_W-1:0] rx,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned BIT_W = clog2_min1(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_q;
  logic [CS_W-1:0]   cs_q;
  logic              cpol_q, cpha_q, lsb_q;
  logic              sclk_q, mosi_q, done_q;
  logic [BIT_W-1:0]  bit_q;
  logic              phase_q;  // 0: next tick is a leading edge, 1: trailing edge

  logic              accept, tick, tick_en;
  logic              lead, trail, advance, sample;
  logic              shift_in, tx_first, in_first;
  logic [DATA_W-1:0] tx_shift, in_shift, rx_next;

  assign accept  = (state_q == IDLE) && start;
  assign tick_en = (state_q != IDLE);

  spi_clk_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .clr (accept),
    .tick(tick)
  );

`ifdef SPI_LOOPBACK_EN
  logic loop_q;
  assign shift_in = loop_q ? mosi_q : miso;
`else
  assign shift_in = miso;
`endif

  assign lead    = (state_q == XFER) && tick && !phase_q;
  assign trail   = (state_q == XFER) && tick && phase_q;
  assign advance = cpha_q ? lead : trail;
  assign sample  = cpha_q ? trail : lead;

  // Bit at the head of the shifter and the shifter after consuming it.
  assign tx_first = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
  assign tx_shift = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
  assign in_first = lsb_first ? tx[0] : tx[DATA_W-1];
  assign in_shift = lsb_first ? (tx >> 1) : (tx << 1);
  assign rx_next  = lsb_q ? {shift_in, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], shift_in};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (tick) state_d = XFER;
      XFER:    if (trail && (bit_q == LAST_BIT)) state_d = HOLD;
      HOLD:    if (tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      cs_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      bit_q   <= '0;
      phase_q <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      loop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      if (accept) begin
        cs_q    <= cs_sel;
        cpol_q  <= cpol;
        cpha_q  <= cpha;
        lsb_q   <= lsb_first;
        sclk_q  <= cpol;
        bit_q   <= '0;
        phase_q <= 1'b0;
`ifdef SPI_LOOPBACK_EN
        loop_q  <= loopback;
`endif
        // cpha=0 presents the first bit before the first leading edge.
        if (!cpha) begin
          mosi_q  <= in_first;
          tx_sh_q <= in_shift;
        end else begin
          tx_sh_q <= tx;
        end
      end
      if ((state_q == XFER) && tick) begin
        sclk_q  <= ~sclk_q;
        phase_q <= ~phase_q;
        if (phase_q) bit_q <= bit_q + BIT_W'(1);
      end
      if (advance) begin
        mosi_q  <= tx_first;
        tx_sh_q <= tx_shift;
      end
      if (sample) rx_sh_q <= rx_next;
      if (state_q == DONE) rx_q <= rx_sh_q;
    end
  end

  assign busy = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);

  always_comb begin
    cs_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (busy && (cs_q == CS_W'(i))) cs_n[i] = 1'b0;
    end
  end

  assign rx   = rx_q;
  assign done = done_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_main_param.sv
module tb_spi_main_param;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, miso;

  // 8-bit instance: CLK_DIV=2, five chip selects (cs_sel is 3 bits wide)
  logic         start8, cpol8, cpha8, lsb8;
  logic [2:0]   sel8;
  logic [7:0]   tx8, rx8;
  logic         busy8, done8, sclk8, mosi8;
  logic [4:0]   csn8;

  // 128-bit instance: CLK_DIV=1, one chip select
  logic         start_w, cpol_w, cpha_w, lsb_w;
  logic [0:0]   sel_w;
  logic [127:0] tx_w, rx_w;
  logic         busy_w, done_w, sclk_w, mosi_w;
  logic [0:0]   csn_w;

  spi_main_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(5)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .cs_sel(sel8), .cpol(cpol8), .cpha(cpha8),
    .lsb_first(lsb8),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx(tx8), .rx(rx8), .busy(busy8), .done(done8), .sclk(sclk8), .mosi(mosi8),
    .miso(miso), .cs_n(csn8)
  );

  spi_main_param #(.DATA_W(128), .CLK_DIV(1), .NUM_CS(1)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .cs_sel(sel_w), .cpol(cpol_w), .cpha(cpha_w),
    .lsb_first(lsb_w),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx(tx_w), .rx(rx_w), .busy(busy_w), .done(done_w), .sclk(sclk_w), .mosi(mosi_w),
    .miso(miso), .cs_n(csn_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sub device model: returns s_val, captures mosi into s_rx, follows s_cpol/s_cpha/s_lsb.
  logic [127:0] s_val, s_rx;
  int           s_w, s_ti, s_ri, sub_sel;
  logic         s_cpol, s_cpha, s_lsb, use_w;
  logic         prev_sclk, prev_act, cur_sclk, cur_mosi, act, s_first;

  function automatic logic sbit(input int i);
    if (i >= s_w) return 1'b0;
    return s_lsb ? s_val[i] : s_val[s_w-1-i];
  endfunction

  task automatic capture();
    if (s_ri == 0) s_first = cur_mosi;
    if (s_ri < s_w) begin
      if (s_lsb) s_rx[s_ri] = cur_mosi;
      else       s_rx[s_w-1-s_ri] = cur_mosi;
    end
    s_ri++;
  endtask

  initial begin
    miso = 1'b0; prev_sclk = 1'b0; prev_act = 1'b0; s_rx = '0; s_ti = 0; s_ri = 0;
    s_first = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    cur_sclk = use_w ? sclk_w : sclk8;
    cur_mosi = use_w ? mosi_w : mosi8;
    act      = use_w ? !csn_w[0] : ((sub_sel < 5) && !csn8[sub_sel]);
    if (act && !prev_act) begin
      s_ti = 0; s_ri = 0; s_rx = '0;
      if (!s_cpha) miso = sbit(0);
    end else if (act && (cur_sclk != prev_sclk)) begin
      if (cur_sclk != s_cpol) begin  // leading edge
        if (s_cpha) begin miso = sbit(s_ti); s_ti++; end
        else capture();
      end else begin                 // trailing edge
        if (s_cpha) capture();
        else begin s_ti++; miso = sbit(s_ti); end
      end
    end
    prev_sclk = cur_sclk;
    prev_act  = act;
  end

  task automatic sub_cfg(input logic [127:0] val, input int w, input logic [1:0] mode,
                         input logic lsb, input int sel, input logic wide);
    s_val = val; s_w = w; s_cpol = mode[1]; s_cpha = mode[0]; s_lsb = lsb;
    sub_sel = sel; use_w = wide;
  endtask

  // One transfer on the 8-bit instance; lat counts cycles from the accepting edge to done.
  task automatic xfer8(input logic [7:0] tx, input logic [2:0] sel, input logic [1:0] mode,
                       input logic lsb, output int lat, output logic busy1,
                       output logic [4:0] cs_acc, output logic sclk_setup);
    @(negedge clk);
    tx8 = tx; sel8 = sel; cpol8 = mode[1]; cpha8 = mode[0]; lsb8 = lsb; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    busy1 = busy8; sclk_setup = sclk8; cs_acc = csn8;
    lat = 0;
    while (lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      cs_acc &= csn8;
      if (done8) break;
    end
  endtask

  int          lat, dcnt;
  logic        b1, ss;
  logic [4:0]  csa;
  logic [1:0]  m;

  initial begin
    rst = 1'b1;
    start8 = 0; cpol8 = 0; cpha8 = 0; lsb8 = 0; sel8 = '0; tx8 = '0;
    start_w = 0; cpol_w = 0; cpha_w = 0; lsb_w = 0; sel_w = '0; tx_w = '0;
    sub_cfg(128'h0, 8, SPI_MODE0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_rx", rx8, 8'h00);
    check("reset_busy", busy8, 1'b0);
    check("reset_done", done8, 1'b0);
    check("reset_cs_n", csn8, 5'h1F);
    check("reset_mosi", mosi8, 1'b0);
    check("reset_sclk", sclk8, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Mode 0, MSB first
    sub_cfg(128'h3C, 8, SPI_MODE0, 1'b0, 0, 1'b0);
    xfer8(8'hA5, 3'd0, SPI_MODE0, 1'b0, lat, b1, csa, ss);
    check("m0_latency", lat, 37);
    check("m0_busy_after_start", b1, 1'b1);
    check("m0_rx", rx8, 8'h3C);
    check("m0_mosi_bits", s_rx[7:0], 8'hA5);
    check("m0_cs_only0", csa, 5'b11110);
    check("m0_done_busy", busy8, 1'b0);
    check("m0_done_cs_n", csn8, 5'h1F);
    @(posedge clk); #1;
    check("m0_done_pulse_1cyc", done8, 1'b0);
    check("m0_sclk_idle", sclk8, 1'b0);

    // Modes 1..3 with an echoing sub
    for (int k = 1; k < 4; k++) begin
      m = 2'(k);
      sub_cfg(128'hC3, 8, m, 1'b0, 0, 1'b0);
      xfer8(8'hC3, 3'd0, m, 1'b0, lat, b1, csa, ss);
      check($sformatf("mode%0d_latency", k), lat, 37);
      check($sformatf("mode%0d_rx", k), rx8, 8'hC3);
      check($sformatf("mode%0d_mosi", k), s_rx[7:0], 8'hC3);
      check($sformatf("mode%0d_sclk_setup", k), ss, m[1]);
      check($sformatf("mode%0d_sclk_idle", k), sclk8, m[1]);
    end

    // LSB first
    sub_cfg(128'h96, 8, SPI_MODE0, 1'b1, 0, 1'b0);
    xfer8(8'h01, 3'd0, SPI_MODE0, 1'b1, lat, b1, csa, ss);
    check("lsb_first_bit", s_first, 1'b1);
    check("lsb_mosi", s_rx[7:0], 8'h01);
    check("lsb_rx", rx8, 8'h96);

    // Reset mid-XFER
    sub_cfg(128'h5A, 8, SPI_MODE0, 1'b0, 0, 1'b0);
    @(negedge clk);
    tx8 = 8'hF0; sel8 = 3'd0; cpol8 = 0; cpha8 = 0; lsb8 = 0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("rst_cs_n", csn8, 5'h1F);
    check("rst_busy", busy8, 1'b0);
    check("rst_rx", rx8, 8'h00);
    check("rst_done", done8, 1'b0);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done8) dcnt++;
    end
    check("rst_no_done", dcnt, 0);
    xfer8(8'h0F, 3'd0, SPI_MODE0, 1'b0, lat, b1, csa, ss);
    check("post_rst_latency", lat, 37);
    check("post_rst_rx", rx8, 8'h5A);

    // Chip-select routing
    sub_cfg(128'h69, 8, SPI_MODE0, 1'b0, 2, 1'b0);
    xfer8(8'h11, 3'd2, SPI_MODE0, 1'b0, lat, b1, csa, ss);
    check("cs2_only", csa, 5'b11011);
    check("cs2_rx", rx8, 8'h69);
    sub_cfg(128'h00, 8, SPI_MODE0, 1'b0, 5, 1'b0);
    xfer8(8'h22, 3'd5, SPI_MODE0, 1'b0, lat, b1, csa, ss);
    check("cs5_none", csa, 5'h1F);
    check("cs5_done_latency", lat, 37);

    // Start pulses while busy are ignored
    sub_cfg(128'hE7, 8, SPI_MODE0, 1'b0, 0, 1'b0);
    @(negedge clk);
    tx8 = 8'h3C; sel8 = 3'd0; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 120; i++) begin
      if (i == 8 || i == 20) begin
        @(negedge clk); start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (done8) dcnt++;
    end
    check("busy_start_ignored", dcnt, 1);
    check("busy_start_rx", rx8, 8'hE7);

    // 128-bit back-to-back with start held high
    sub_cfg(128'hfedcba98765432100123456789abcdef, 128, SPI_MODE0, 1'b0, 0, 1'b1);
    @(negedge clk);
    tx_w = 128'h00112233445566778899aabbccddeeff; start_w = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk); #1; lat++;
      if (done_w) break;
    end
    check("w_latency1", lat, 259);
    check("w_rx1", rx_w, 128'hfedcba98765432100123456789abcdef);
    check("w_mosi1", s_rx, 128'h00112233445566778899aabbccddeeff);
    @(posedge clk); #1;
    check("w_second_started", busy_w, 1'b1);
    start_w = 1'b0;
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk); #1; lat++;
      if (done_w) break;
    end
    check("w_latency2", lat, 259);
    check("w_rx2", rx_w, 128'hfedcba98765432100123456789abcdef);
    repeat (3) @(posedge clk);
    #1;
    check("w_no_third", busy_w, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
